// File: rtl/decode_stage.sv
// Decode stage of a five-stage in-order pipeline: decodes the instruction held in the
// IF/ID register, resolves branches and detects RAW hazards. Define DECODE_FORWARD_EN to
// forward EX/MEM/WB results instead of stalling on every in-flight producer.
module decode_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_valid,
    input  logic [31:0]  if_inst,
    input  logic [31:0]  if_pc,
    output logic         id_allow_in,
    output logic         br_taken,
    output logic         br_taken_cancel,
    output logic [31:0]  br_target,
    output logic [4:0]   rf_raddr1,
    output logic [4:0]   rf_raddr2,
    input  logic [31:0]  rf_rdata1,
    input  logic [31:0]  rf_rdata2,
    input  logic         ex_allow_in,
    output logic         id_to_ex_valid,
    output logic [147:0] id_to_ex_bus,
    input  logic [39:0]  ex_fwd_bus,
    input  logic [38:0]  mem_fwd_bus,
    input  logic [38:0]  wb_fwd_bus
);

    function automatic logic hit(input logic v, input logic we, input logic [4:0] d,
                                 input logic [4:0] s);
        return v && we && (d == s) && (s != 5'd0);
    endfunction

    logic        id_valid_q, id_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        ready_go, taken;
    logic [31:0] val1, val2, src2;

    logic [4:0] rd, rj, rk;
    assign rd = inst_q[4:0];
    assign rj = inst_q[9:5];
    assign rk = inst_q[14:10];

    logic is_add, is_sub, is_slt, is_sltu, is_and, is_or, is_xor, is_nor;
    logic is_slli, is_srli, is_srai, is_addi, is_lu12i, is_ld, is_st;
    logic is_jirl, is_b, is_bl, is_beq, is_bne, is_3r, is_shift;
    assign is_add   = inst_q[31:15] == 17'b00000000000100000;
    assign is_sub   = inst_q[31:15] == 17'b00000000000100010;
    assign is_slt   = inst_q[31:15] == 17'b00000000000100100;
    assign is_sltu  = inst_q[31:15] == 17'b00000000000100101;
    assign is_nor   = inst_q[31:15] == 17'b00000000000101000;
    assign is_and   = inst_q[31:15] == 17'b00000000000101001;
    assign is_or    = inst_q[31:15] == 17'b00000000000101010;
    assign is_xor   = inst_q[31:15] == 17'b00000000000101011;
    assign is_slli  = inst_q[31:15] == 17'b00000000010000001;
    assign is_srli  = inst_q[31:15] == 17'b00000000010001001;
    assign is_srai  = inst_q[31:15] == 17'b00000000010010001;
    assign is_addi  = inst_q[31:22] == 10'b0000001010;
    assign is_ld    = inst_q[31:22] == 10'b0010100010;
    assign is_st    = inst_q[31:22] == 10'b0010100110;
    assign is_lu12i = inst_q[31:25] == 7'b0001010;
    assign is_jirl  = inst_q[31:26] == 6'b010011;
    assign is_b     = inst_q[31:26] == 6'b010100;
    assign is_bl    = inst_q[31:26] == 6'b010101;
    assign is_beq   = inst_q[31:26] == 6'b010110;
    assign is_bne   = inst_q[31:26] == 6'b010111;
    assign is_3r    = is_add | is_sub | is_slt | is_sltu | is_and | is_or | is_xor | is_nor;
    assign is_shift = is_slli | is_srli | is_srai;

    // Stores and compare-branches read rd through the second port
    logic use_rj, use_r2, r2_is_rd;
    assign r2_is_rd  = is_st | is_beq | is_bne;
    assign use_rj    = is_3r | is_shift | is_addi | is_ld | is_st | is_jirl | is_beq | is_bne;
    assign use_r2    = is_3r | r2_is_rd;
    assign rf_raddr1 = rj;
    assign rf_raddr2 = r2_is_rd ? rd : rk;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    assign ex_hit1  = hit(ex_fwd_bus[39], ex_fwd_bus[38], ex_fwd_bus[36:32], rf_raddr1);
    assign ex_hit2  = hit(ex_fwd_bus[39], ex_fwd_bus[38], ex_fwd_bus[36:32], rf_raddr2);
    assign mem_hit1 = hit(mem_fwd_bus[38], mem_fwd_bus[37], mem_fwd_bus[36:32], rf_raddr1);
    assign mem_hit2 = hit(mem_fwd_bus[38], mem_fwd_bus[37], mem_fwd_bus[36:32], rf_raddr2);
    assign wb_hit1  = hit(wb_fwd_bus[38], wb_fwd_bus[37], wb_fwd_bus[36:32], rf_raddr1);
    assign wb_hit2  = hit(wb_fwd_bus[38], wb_fwd_bus[37], wb_fwd_bus[36:32], rf_raddr2);

`ifndef DECODE_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_bus[37], ex_fwd_bus[31:0], mem_fwd_bus[31:0], wb_fwd_bus[31:0]};
`endif

    // Operand selection and issue readiness; youngest producer wins
    always_comb begin
        val1     = rf_rdata1;
        val2     = rf_rdata2;
        ready_go = 1'b1;
`ifdef DECODE_FORWARD_EN
        if (ex_hit1)       val1 = ex_fwd_bus[31:0];
        else if (mem_hit1) val1 = mem_fwd_bus[31:0];
        else if (wb_hit1)  val1 = wb_fwd_bus[31:0];
        else               val1 = rf_rdata1;
        if (ex_hit2)       val2 = ex_fwd_bus[31:0];
        else if (mem_hit2) val2 = mem_fwd_bus[31:0];
        else if (wb_hit2)  val2 = wb_fwd_bus[31:0];
        else               val2 = rf_rdata2;
        ready_go = !(ex_fwd_bus[37] && ((use_rj && ex_hit1) || (use_r2 && ex_hit2)));
`else
        ready_go = !((use_rj && (ex_hit1 || mem_hit1 || wb_hit1)) ||
                     (use_r2 && (ex_hit2 || mem_hit2 || wb_hit2)));
`endif
    end

    // Second ALU operand: immediates take precedence over the register value
    always_comb begin
        src2 = val2;
        if (is_addi | is_ld | is_st)  src2 = {{20{inst_q[21]}}, inst_q[21:10]};
        else if (is_shift)            src2 = {27'd0, inst_q[14:10]};
        else if (is_lu12i)            src2 = {inst_q[24:5], 12'd0};
        else if (is_bl | is_jirl)     src2 = 32'd4;
        else                          src2 = val2;
    end

    logic [31:0] off16, off26;
    assign off16 = {{14{inst_q[25]}}, inst_q[25:10], 2'b00};
    assign off26 = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b00};

    // Branch resolution
    always_comb begin
        taken     = is_b | is_bl | is_jirl | (is_beq & (val1 == val2)) | (is_bne & (val1 != val2));
        br_target = pc_q + off16;
        if (is_b | is_bl)  br_target = pc_q + off26;
        else if (is_jirl)  br_target = val1 + off16;
        else               br_target = pc_q + off16;
    end

    logic [11:0] alu_op;
    logic [4:0]  dest;
    logic        gr_we;
    assign alu_op = {is_lu12i, is_srai, is_srli, is_slli, is_xor, is_or, is_nor, is_and,
                     is_sltu, is_slt, is_sub,
                     is_add | is_addi | is_ld | is_st | is_jirl | is_bl};
    assign dest   = is_bl ? 5'd1 : rd;
    assign gr_we  = (is_3r | is_shift | is_addi | is_lu12i | is_ld | is_jirl | is_bl) &&
                    (dest != 5'd0);

    assign id_allow_in     = !id_valid_q || (ready_go && ex_allow_in);
    assign id_to_ex_valid  = id_valid_q && ready_go;
    assign br_taken        = id_valid_q && ready_go && taken;
    assign br_taken_cancel = br_taken;
    assign id_to_ex_bus    = {alu_op, (is_jirl | is_bl) ? pc_q : val1, src2, dest, gr_we,
                              is_st, is_ld, val2, pc_q};

    // IF/ID register next state; a wrong-path fetch is dropped while redirecting
    always_comb begin
        id_valid_d = id_valid_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        if (id_allow_in) begin
            id_valid_d = if_valid && !br_taken;
            inst_d     = if_inst;
            pc_d       = if_pc;
        end else begin
            id_valid_d = id_valid_q;
        end
    end

    // IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            inst_q     <= 32'd0;
            pc_q       <= 32'd0;
        end else begin
            id_valid_q <= id_valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized instructions
// checked against an instruction-level reference model. Honors DECODE_FORWARD_EN.
module tb_decode_stage;

    logic         clk = 1'b0;
    logic         reset, if_valid, ex_allow_in;
    logic [31:0]  if_inst, if_pc;
    logic         id_allow_in, br_taken, br_taken_cancel, id_to_ex_valid;
    logic [31:0]  br_target, rf_rdata1, rf_rdata2;
    logic [4:0]   rf_raddr1, rf_raddr2;
    logic [147:0] id_to_ex_bus;
    logic [39:0]  ex_fwd_bus;
    logic [38:0]  mem_fwd_bus, wb_fwd_bus;

    logic        ex_v, ex_we, ex_ld, mem_v, mem_we, wb_v, wb_we;
    logic [4:0]  ex_d, mem_d, wb_d;
    logic [31:0] ex_r, mem_r, wb_r;
    logic [31:0] rf [32];

    int n_pass  = 0;
    int n_total = 0;

    typedef enum int {M_ADD, M_SUB, M_SLT, M_SLTU, M_AND, M_OR, M_XOR, M_NOR,
                      M_SLLI, M_SRLI, M_SRAI, M_ADDI, M_LU12I, M_LD, M_ST,
                      M_JIRL, M_B, M_BL, M_BEQ, M_BNE, M_NOP} mn_t;

    logic [147:0] exp_bus;
    logic         exp_stall, exp_taken;
    logic [31:0]  exp_target;

    always #5 clk = ~clk;

    assign ex_fwd_bus  = {ex_v, ex_we, ex_ld, ex_d, ex_r};
    assign mem_fwd_bus = {mem_v, mem_we, mem_d, mem_r};
    assign wb_fwd_bus  = {wb_v, wb_we, wb_d, wb_r};
    assign rf_rdata1   = rf[rf_raddr1];
    assign rf_rdata2   = rf[rf_raddr2];

    decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_allow_in(id_allow_in), .br_taken(br_taken), .br_taken_cancel(br_taken_cancel),
        .br_target(br_target), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_allow_in(ex_allow_in),
        .id_to_ex_valid(id_to_ex_valid), .id_to_ex_bus(id_to_ex_bus),
        .ex_fwd_bus(ex_fwd_bus), .mem_fwd_bus(mem_fwd_bus), .wb_fwd_bus(wb_fwd_bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_v = 1'b0; ex_we = 1'b0; ex_ld = 1'b0; ex_d = 5'd0; ex_r = 32'd0;
        mem_v = 1'b0; mem_we = 1'b0; mem_d = 5'd0; mem_r = 32'd0;
        wb_v = 1'b0; wb_we = 1'b0; wb_d = 5'd0; wb_r = 32'd0;
    endtask

    function automatic logic [31:0] enc(input mn_t m, input logic [4:0] rd,
                                        input logic [4:0] rj, input logic [4:0] rk,
                                        input logic [31:0] imm);
        case (m)
            M_ADD:   return {17'b00000000000100000, rk, rj, rd};
            M_SUB:   return {17'b00000000000100010, rk, rj, rd};
            M_SLT:   return {17'b00000000000100100, rk, rj, rd};
            M_SLTU:  return {17'b00000000000100101, rk, rj, rd};
            M_NOR:   return {17'b00000000000101000, rk, rj, rd};
            M_AND:   return {17'b00000000000101001, rk, rj, rd};
            M_OR:    return {17'b00000000000101010, rk, rj, rd};
            M_XOR:   return {17'b00000000000101011, rk, rj, rd};
            M_SLLI:  return {17'b00000000010000001, rk, rj, rd};
            M_SRLI:  return {17'b00000000010001001, rk, rj, rd};
            M_SRAI:  return {17'b00000000010010001, rk, rj, rd};
            M_ADDI:  return {10'b0000001010, imm[11:0], rj, rd};
            M_LD:    return {10'b0010100010, imm[11:0], rj, rd};
            M_ST:    return {10'b0010100110, imm[11:0], rj, rd};
            M_LU12I: return {7'b0001010, imm[19:0], rd};
            M_JIRL:  return {6'b010011, imm[15:0], rj, rd};
            M_BEQ:   return {6'b010110, imm[15:0], rj, rd};
            M_BNE:   return {6'b010111, imm[15:0], rj, rd};
            M_B:     return {6'b010100, imm[15:0], imm[25:16]};
            M_BL:    return {6'b010101, imm[15:0], imm[25:16]};
            default: return {6'b111111, imm[25:0]};
        endcase
    endfunction

    // Architectural value a reader of register r sees this cycle
    function automatic logic [31:0] reg_val(input logic [4:0] r);
`ifdef DECODE_FORWARD_EN
        if (r != 5'd0 && ex_v && ex_we && ex_d == r) return ex_r;
        if (r != 5'd0 && mem_v && mem_we && mem_d == r) return mem_r;
        if (r != 5'd0 && wb_v && wb_we && wb_d == r) return wb_r;
`endif
        return rf[r];
    endfunction

    function automatic logic blocks(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
`ifdef DECODE_FORWARD_EN
        return ex_v && ex_we && ex_ld && ex_d == r;
`else
        return (ex_v && ex_we && ex_d == r) || (mem_v && mem_we && mem_d == r) ||
               (wb_v && wb_we && wb_d == r);
`endif
    endfunction

    task automatic model(input mn_t m, input logic [31:0] ins, input logic [31:0] pcv);
        logic [4:0]  rd, rj, rk, r2, dest;
        logic [31:0] a, b, s1, s2;
        logic [11:0] alu;
        logic signed [11:0] s12;
        logic signed [15:0] o16;
        logic signed [25:0] o26;
        logic use_j, use_2, writes, gwe;
        rd  = ins[4:0];
        rj  = ins[9:5];
        rk  = ins[14:10];
        s12 = ins[21:10];
        o16 = ins[25:10];
        o26 = {ins[9:0], ins[25:10]};
        r2  = (m == M_ST || m == M_BEQ || m == M_BNE) ? rd : rk;
        a   = reg_val(rj);
        b   = reg_val(r2);
        use_j = !(m inside {M_LU12I, M_B, M_BL, M_NOP});
        use_2 = (m <= M_NOR) || m == M_ST || m == M_BEQ || m == M_BNE;
        exp_stall = (use_j && blocks(rj)) || (use_2 && blocks(r2));
        alu = 12'd0;
        case (m)
            M_ADD, M_ADDI, M_LD, M_ST, M_JIRL, M_BL: alu[0] = 1'b1;
            M_SUB:   alu[1]  = 1'b1;
            M_SLT:   alu[2]  = 1'b1;
            M_SLTU:  alu[3]  = 1'b1;
            M_AND:   alu[4]  = 1'b1;
            M_NOR:   alu[5]  = 1'b1;
            M_OR:    alu[6]  = 1'b1;
            M_XOR:   alu[7]  = 1'b1;
            M_SLLI:  alu[8]  = 1'b1;
            M_SRLI:  alu[9]  = 1'b1;
            M_SRAI:  alu[10] = 1'b1;
            M_LU12I: alu[11] = 1'b1;
            default: alu = 12'd0;
        endcase
        s1 = (m == M_JIRL || m == M_BL) ? pcv : a;
        case (m)
            M_ADDI, M_LD, M_ST:   s2 = int'(s12);
            M_SLLI, M_SRLI, M_SRAI: s2 = 32'(rk);
            M_LU12I:              s2 = 32'(ins[24:5]) * 32'd4096;
            M_JIRL, M_BL:         s2 = 32'd4;
            default:              s2 = b;
        endcase
        dest   = (m == M_BL) ? 5'd1 : rd;
        writes = (m <= M_LU12I) || m == M_LD || m == M_JIRL || m == M_BL;
        gwe    = writes && dest != 5'd0;
        exp_bus = {alu, s1, s2, dest, gwe, m == M_ST, m == M_LD, b, pcv};
        exp_taken  = 1'b0;
        exp_target = 32'd0;
        case (m)
            M_B, M_BL: begin exp_taken = 1'b1;   exp_target = pcv + 32'(int'(o26) * 4); end
            M_BEQ:     begin exp_taken = a == b; exp_target = pcv + 32'(int'(o16) * 4); end
            M_BNE:     begin exp_taken = a != b; exp_target = pcv + 32'(int'(o16) * 4); end
            M_JIRL:    begin exp_taken = 1'b1;   exp_target = a + 32'(int'(o16) * 4); end
            default:   begin exp_taken = 1'b0;   exp_target = 32'd0; end
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1; if_valid = 1'b1; if_inst = 32'h0; if_pc = 32'h0; ex_allow_in = 1'b1;
        clear_fwd();
        step(); step();
        reset = 1'b0; if_valid = 1'b0;
        #1;
        n_total++; if ({id_to_ex_valid, br_taken, br_taken_cancel, id_allow_in} !== 4'b0001)
            $display("FAIL reset_outputs: got %b expected 0001", {id_to_ex_valid, br_taken, br_taken_cancel, id_allow_in}); else n_pass++;
        // pending taken branch stalled downstream, then reset
        rf[1] = 32'h55;
        if_valid = 1'b1; if_inst = enc(M_BEQ, 5'd1, 5'd1, 5'd0, 32'd4); if_pc = 32'h100;
        step();
        ex_allow_in = 1'b0; if_valid = 1'b0;
        #1;
        n_total++; if ({br_taken, id_allow_in} !== 2'b10)
            $display("FAIL reset_pending_setup: got %b expected 10", {br_taken, id_allow_in}); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0; ex_allow_in = 1'b1;
        #1;
        n_total++; if ({id_to_ex_valid, br_taken, br_taken_cancel, id_allow_in} !== 4'b0001)
            $display("FAIL reset_override: got %b expected 0001", {id_to_ex_valid, br_taken, br_taken_cancel, id_allow_in}); else n_pass++;
    endtask

    task automatic test_addi();
        if_valid = 1'b1; if_inst = enc(M_ADDI, 5'd1, 5'd0, 5'd0, 32'd5); if_pc = 32'h1c000000;
        step();
        if_valid = 1'b0;
        #1;
        n_total++; if (id_to_ex_valid !== 1'b1) $display("FAIL addi_valid: got %b expected 1", id_to_ex_valid); else n_pass++;
        n_total++; if (id_to_ex_bus[103:72] !== 32'd5) $display("FAIL addi_src2: got %h expected 5", id_to_ex_bus[103:72]); else n_pass++;
        n_total++; if (id_to_ex_bus[71:67] !== 5'd1) $display("FAIL addi_dest: got %0d expected 1", id_to_ex_bus[71:67]); else n_pass++;
        n_total++; if (id_to_ex_bus[66] !== 1'b1) $display("FAIL addi_gr_we: got %b expected 1", id_to_ex_bus[66]); else n_pass++;
        n_total++; if (id_to_ex_bus[31:0] !== 32'h1c000000) $display("FAIL addi_pc: got %h expected 1c000000", id_to_ex_bus[31:0]); else n_pass++;
        step();
    endtask

    task automatic test_branch();
        rf[1] = 32'd3; rf[2] = 32'd3;
        if_valid = 1'b1; if_inst = enc(M_BEQ, 5'd2, 5'd1, 5'd0, 32'd2); if_pc = 32'h1c000010;
        step();
        if_inst = enc(M_ADD, 5'd9, 5'd1, 5'd2, 32'd0); if_pc = 32'h1c000014;
        #1;
        n_total++; if ({br_taken, br_taken_cancel} !== 2'b11) $display("FAIL beq_taken: got %b expected 11", {br_taken, br_taken_cancel}); else n_pass++;
        n_total++; if (br_target !== 32'h1c000018) $display("FAIL beq_target: got %h expected 1c000018", br_target); else n_pass++;
        step();
        if_valid = 1'b0;
        #1;
        n_total++; if ({id_to_ex_valid, br_taken} !== 2'b00) $display("FAIL wrong_path_dropped: got %b expected 00", {id_to_ex_valid, br_taken}); else n_pass++;
    endtask

`ifdef DECODE_FORWARD_EN
    task automatic test_load_use();
        rf[4] = 32'hAAAA;
        ex_v = 1'b1; ex_we = 1'b1; ex_ld = 1'b1; ex_d = 5'd4; ex_r = 32'hDEAD;
        if_valid = 1'b1; if_inst = enc(M_ADD, 5'd5, 5'd4, 5'd4, 32'd0); if_pc = 32'h200;
        step();
        if_valid = 1'b0;
        #1;
        n_total++; if ({id_to_ex_valid, id_allow_in} !== 2'b00) $display("FAIL load_use_stall: got %b expected 00", {id_to_ex_valid, id_allow_in}); else n_pass++;
        step();
        clear_fwd();
        mem_v = 1'b1; mem_we = 1'b1; mem_d = 5'd4; mem_r = 32'h1234;
        #1;
        n_total++; if (id_to_ex_valid !== 1'b1) $display("FAIL load_use_release: got %b expected 1", id_to_ex_valid); else n_pass++;
        n_total++; if (id_to_ex_bus[135:72] !== {32'h1234, 32'h1234}) $display("FAIL load_use_fwd_data: got %h expected 0000123400001234", id_to_ex_bus[135:72]); else n_pass++;
        step();
        clear_fwd();
    endtask
`else
    task automatic test_fwd_off();
        rf[6] = 32'h66; rf[1] = 32'h11;
        mem_v = 1'b1; mem_we = 1'b1; mem_d = 5'd6; mem_r = 32'hBEEF;
        if_valid = 1'b1; if_inst = enc(M_ADD, 5'd7, 5'd6, 5'd1, 32'd0); if_pc = 32'h300;
        step();
        if_valid = 1'b0;
        #1;
        n_total++; if ({id_to_ex_valid, id_allow_in} !== 2'b00) $display("FAIL nofwd_mem_stall: got %b expected 00", {id_to_ex_valid, id_allow_in}); else n_pass++;
        step();
        clear_fwd();
        wb_v = 1'b1; wb_we = 1'b1; wb_d = 5'd6; wb_r = 32'hBEEF;
        #1;
        n_total++; if ({id_to_ex_valid, id_allow_in} !== 2'b00) $display("FAIL nofwd_wb_stall: got %b expected 00", {id_to_ex_valid, id_allow_in}); else n_pass++;
        step();
        clear_fwd();
        rf[6] = 32'h6060;
        #1;
        n_total++; if (id_to_ex_valid !== 1'b1) $display("FAIL nofwd_release: got %b expected 1", id_to_ex_valid); else n_pass++;
        n_total++; if (id_to_ex_bus[135:104] !== 32'h6060) $display("FAIL nofwd_rf_data: got %h expected 6060", id_to_ex_bus[135:104]); else n_pass++;
        step();
    endtask
`endif

    task automatic test_ex_backpressure();
        logic [31:0] ins;
        int issues;
        issues = 0;
        rf[1] = 32'h1111; rf[2] = 32'h2222;
        ins = enc(M_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        if_valid = 1'b1; if_inst = ins; if_pc = 32'h400;
        step();
        ex_allow_in = 1'b0;
        if_inst = enc(M_SUB, 5'd8, 5'd8, 5'd8, 32'd0); if_pc = 32'h404;
        model(M_ADD, ins, 32'h400);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (id_allow_in !== 1'b0) $display("FAIL bp_allow_in[%0d]: got %b expected 0", i, id_allow_in); else n_pass++;
            n_total++; if (id_to_ex_bus !== exp_bus) $display("FAIL bp_bus_hold[%0d]: got %h expected %h", i, id_to_ex_bus, exp_bus); else n_pass++;
            if (id_to_ex_valid && ex_allow_in) issues++;
            step();
        end
        ex_allow_in = 1'b1;
        #1;
        n_total++; if ({id_allow_in, id_to_ex_valid} !== 2'b11) $display("FAIL bp_release: got %b expected 11", {id_allow_in, id_to_ex_valid}); else n_pass++;
        n_total++; if (id_to_ex_bus !== exp_bus) $display("FAIL bp_release_bus: got %h expected %h", id_to_ex_bus, exp_bus); else n_pass++;
        if (id_to_ex_valid && ex_allow_in) issues++;
        if_valid = 1'b0;
        step();
        if (id_to_ex_valid && ex_allow_in) issues++;
        n_total++; if (issues !== 1) $display("FAIL bp_issue_count: got %0d expected 1", issues); else n_pass++;
    endtask

    task automatic test_r0();
        rf[1] = 32'd7; rf[2] = 32'd9;
        if_valid = 1'b1; if_inst = enc(M_ADD, 5'd0, 5'd1, 5'd2, 32'd0); if_pc = 32'h500;
        step();
        if_inst = enc(M_ADD, 5'd3, 5'd0, 5'd0, 32'd0); if_pc = 32'h504;
        #1;
        n_total++; if (id_to_ex_bus[66] !== 1'b0) $display("FAIL r0_gr_we: got %b expected 0", id_to_ex_bus[66]); else n_pass++;
        step();
        if_valid = 1'b0;
        ex_v = 1'b1; ex_we = 1'b1; ex_ld = 1'b1; ex_d = 5'd0; ex_r = 32'hBAD;
        mem_v = 1'b1; mem_we = 1'b1; mem_d = 5'd0; mem_r = 32'hBAD;
        #1;
        n_total++; if (id_to_ex_valid !== 1'b1) $display("FAIL r0_no_stall: got %b expected 1", id_to_ex_valid); else n_pass++;
        n_total++; if (id_to_ex_bus[135:72] !== 64'd0) $display("FAIL r0_operands: got %h expected 0", id_to_ex_bus[135:72]); else n_pass++;
        step();
        clear_fwd();
    endtask

    task automatic test_random();
        mn_t m;
        logic [31:0] ins, pcv;
        for (int it = 0; it < 300; it++) begin
            clear_fwd();
            for (int r = 1; r < 32; r++) rf[r] = ($urandom_range(0, 3) == 0) ? rf[r % 4] : $urandom;
            m   = mn_t'($urandom_range(0, 20));
            ins = enc(m, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), $urandom);
            pcv = $urandom & 32'hFFFF_FFFC;
            if_valid = 1'b1; if_inst = ins; if_pc = pcv; ex_allow_in = 1'b1;
            step();
            if_valid = 1'b0;
            ex_v = 1'($urandom); ex_we = 1'($urandom); ex_ld = 1'($urandom);
            ex_d = 5'($urandom_range(0, 7)); ex_r = $urandom;
            mem_v = 1'($urandom); mem_we = 1'($urandom);
            mem_d = 5'($urandom_range(0, 7)); mem_r = $urandom;
            wb_v = 1'($urandom); wb_we = 1'($urandom);
            wb_d = 5'($urandom_range(0, 7)); wb_r = $urandom;
            #1;
            model(m, ins, pcv);
            if (exp_stall) begin
                n_total++; if ({id_to_ex_valid, id_allow_in, br_taken} !== 3'b000)
                    $display("FAIL rand_stall[%0d] mn=%0d: got %b expected 000", it, m, {id_to_ex_valid, id_allow_in, br_taken}); else n_pass++;
            end else begin
                n_total++; if ({id_to_ex_valid, id_allow_in} !== 2'b11)
                    $display("FAIL rand_issue[%0d] mn=%0d: got %b expected 11", it, m, {id_to_ex_valid, id_allow_in}); else n_pass++;
                n_total++; if (id_to_ex_bus !== exp_bus)
                    $display("FAIL rand_bus[%0d] mn=%0d: got %h expected %h", it, m, id_to_ex_bus, exp_bus); else n_pass++;
                n_total++; if ({br_taken, br_taken_cancel} !== {exp_taken, exp_taken})
                    $display("FAIL rand_taken[%0d] mn=%0d: got %b expected %b", it, m, {br_taken, br_taken_cancel}, {exp_taken, exp_taken}); else n_pass++;
                if (exp_taken) begin
                    n_total++; if (br_target !== exp_target)
                        $display("FAIL rand_target[%0d] mn=%0d: got %h expected %h", it, m, br_target, exp_target); else n_pass++;
                end
            end
            clear_fwd();
            step();
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : 32'h100 + 32'(r);
        test_reset();
        test_addi();
        test_branch();
`ifdef DECODE_FORWARD_EN
        test_load_use();
`else
        test_fwd_off();
`endif
        test_ex_backpressure();
        test_r0();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
